alu_issue: RTL and testbench

Issue stage that drives the execute ALU's `alu_ctr` / `alu_op1` / `alu_op2` inputs.
- Accepts an RV32I/M register-register or register-immediate instruction plus the two register-file read values over a valid/ready handshake.
- Decodes the instruction to the team's 5-bit ALU operation code, forms both operands, and holds them in a one-entry output register for the ALU.
- DIV/DIVU/REM/REMU are held stable for a programmable number of cycles before they are presented valid, so the combinational divider can be timed as a multicycle path.

---
 rtl/alu_issue.sv | 206 ++++++++++++++++++++
 tb/tb_alu_issue.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue stage for the execute ALU: decodes RV32I/M OP and OP-IMM into a 5-bit ALU code plus operands.
// Build option ALU_ISSUE_M_EN enables the M extension and the divide hold (multicycle) path.
module alu_issue #(
  parameter int ALUCTR_WIDTH = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int MDIV_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             instr,
  input  logic [DATA_WIDTH-1:0]   rs1_data,
  input  logic [DATA_WIDTH-1:0]   rs2_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ALUCTR_WIDTH-1:0] alu_ctr,
  output logic [DATA_WIDTH-1:0]   alu_op1,
  output logic [DATA_WIDTH-1:0]   alu_op2,
  output logic                    illegal,
  output logic [1:0]              dbg_state
);

  // Handshake: a transfer happens on a cycle where valid and ready are both high at the rising edge;
  // valid never depends on ready, and once raised it stays high with stable payload until taken.

  typedef enum logic [1:0] {EMPTY = 2'd0, HOLD = 2'd1, FULL = 2'd2} state_t;

  localparam logic [ALUCTR_WIDTH-1:0] C_ADD  = ALUCTR_WIDTH'(0);
  localparam logic [ALUCTR_WIDTH-1:0] C_SUB  = ALUCTR_WIDTH'(1);
  localparam logic [ALUCTR_WIDTH-1:0] C_SLL  = ALUCTR_WIDTH'(2);
  localparam logic [ALUCTR_WIDTH-1:0] C_SLT  = ALUCTR_WIDTH'(3);
  localparam logic [ALUCTR_WIDTH-1:0] C_SLTU = ALUCTR_WIDTH'(4);
  localparam logic [ALUCTR_WIDTH-1:0] C_XOR  = ALUCTR_WIDTH'(5);
  localparam logic [ALUCTR_WIDTH-1:0] C_SRL  = ALUCTR_WIDTH'(6);
  localparam logic [ALUCTR_WIDTH-1:0] C_SRA  = ALUCTR_WIDTH'(7);
  localparam logic [ALUCTR_WIDTH-1:0] C_OR   = ALUCTR_WIDTH'(8);
  localparam logic [ALUCTR_WIDTH-1:0] C_AND  = ALUCTR_WIDTH'(9);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  state_t state_q, state_d, load_state;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [DATA_WIDTH-1:0] imm_s, shamt_i, shamt_r;
  logic [ALUCTR_WIDTH-1:0] dec_ctr;
  logic [DATA_WIDTH-1:0] dec_op1, dec_op2;
  logic dec_ill;
  logic accept;

  logic [ALUCTR_WIDTH-1:0] ctr_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q;
  logic ill_q;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_s   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign shamt_i = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
  assign shamt_r = {{(DATA_WIDTH-5){1'b0}}, rs2_data[4:0]};

  // Register and source-select fields are resolved before this stage.
  logic unused_fields;
  assign unused_fields = ^{instr[19:15], instr[11:7]};

`ifdef ALU_ISSUE_M_EN
  localparam logic [ALUCTR_WIDTH-1:0] C_MUL = ALUCTR_WIDTH'(10);
  localparam int CW = 4;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dec_div;
  assign dec_div = (opcode == OPC_OP) && (funct7 == 7'b0000001) && funct3[2];
`else
  logic unused_cfg;
  assign unused_cfg = (MDIV_CYCLES > 1);
`endif

  always_comb begin
    dec_ctr = C_ADD;
    dec_op1 = rs1_data;
    dec_op2 = rs2_data;
    dec_ill = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        unique case (funct7)
          7'b0000000: begin
            unique case (funct3)
              3'd0: dec_ctr = C_ADD;
              3'd1: begin dec_ctr = C_SLL; dec_op2 = shamt_r; end
              3'd2: dec_ctr = C_SLT;
              3'd3: dec_ctr = C_SLTU;
              3'd4: dec_ctr = C_XOR;
              3'd5: begin dec_ctr = C_SRL; dec_op2 = shamt_r; end
              3'd6: dec_ctr = C_OR;
              default: dec_ctr = C_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'd0) dec_ctr = C_SUB;
            else if (funct3 == 3'd5) begin dec_ctr = C_SRA; dec_op2 = shamt_r; end
            else dec_ill = 1'b1;
          end
`ifdef ALU_ISSUE_M_EN
          // M-extension codes are contiguous in funct3 order starting at MUL.
          7'b0000001: dec_ctr = C_MUL + ALUCTR_WIDTH'(funct3);
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_op2 = imm_s;
        unique case (funct3)
          3'd0: dec_ctr = C_ADD;
          3'd2: dec_ctr = C_SLT;
          3'd3: dec_ctr = C_SLTU;
          3'd4: dec_ctr = C_XOR;
          3'd6: dec_ctr = C_OR;
          3'd7: dec_ctr = C_AND;
          3'd1: begin
            dec_op2 = shamt_i;
            if (funct7 == 7'b0000000) dec_ctr = C_SLL;
            else dec_ill = 1'b1;
          end
          default: begin
            dec_op2 = shamt_i;
            if (funct7 == 7'b0000000) dec_ctr = C_SRL;
            else if (funct7 == 7'b0100000) dec_ctr = C_SRA;
            else dec_ill = 1'b1;
          end
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_ctr = '0;
      dec_op1 = '0;
      dec_op2 = '0;
    end
  end

  assign in_ready  = (state_q == EMPTY) || ((state_q == FULL) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == FULL);
  assign dbg_state = state_q;
  assign alu_ctr   = ctr_q;
  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign illegal   = ill_q;

  always_comb begin
    load_state = FULL;
`ifdef ALU_ISSUE_M_EN
    if (dec_div && (MDIV_CYCLES > 1)) load_state = HOLD;
`endif
  end

  always_comb begin
    state_d = state_q;
`ifdef ALU_ISSUE_M_EN
    cnt_d = cnt_q;
    if (accept && (load_state == HOLD)) cnt_d = CW'(MDIV_CYCLES - 1);
`endif
    unique case (state_q)
      EMPTY: if (accept) state_d = load_state;
      FULL: begin
        if (accept) state_d = load_state;
        else if (out_ready) state_d = EMPTY;
      end
      HOLD: begin
`ifdef ALU_ISSUE_M_EN
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FULL;
`else
        state_d = EMPTY;
`endif
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ctr_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      ill_q   <= 1'b0;
`ifdef ALU_ISSUE_M_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ALU_ISSUE_M_EN
      cnt_q   <= cnt_d;
`endif
      if (accept) begin
        ctr_q <= dec_ctr;
        op1_q <= dec_op1;
        op2_q <= dec_op2;
        ill_q <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus a randomized stream against an
// encoder-driven reference model (expected code comes from the mnemonic chosen, not from decoding).
module tb_alu_issue;
  localparam int MDIV = 4;
  localparam int EW = 71;
`ifdef ALU_ISSUE_M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, illegal;
  logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0, alu_op1, alu_op2;
  logic [4:0] alu_ctr;
  logic [1:0] dbg_state;

  alu_issue #(.ALUCTR_WIDTH(5), .DATA_WIDTH(32), .MDIV_CYCLES(MDIV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctr(alu_ctr), .alu_op1(alu_op1), .alu_op2(alu_op2), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Entry: {is_div, illegal, ctr[4:0], op1[31:0], op2[31:0]}
  logic [EW-1:0] exp_q[$];
  wire [EW-1:0] obs = {out_valid, illegal, alu_ctr, alu_op1, alu_op2};

  // ---------------- encoders and reference model ----------------
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3, logic [4:0] a, logic [4:0] b, logic [4:0] d);
    return {f7, b, a, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [2:0] f3, logic [4:0] a, logic [4:0] d);
    return {imm, a, f3, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] sext12(logic [11:0] v);
    int s;
    s = int'(v);
    if (s > 2047) s = s - 4096;
    return 32'(s);
  endfunction

  // Register-register mnemonic k (k is also its ALU code): {funct7, funct3}
  function automatic logic [9:0] r_code(int k);
    case (k)
      0: return {7'h00, 3'd0};  1: return {7'h20, 3'd0};  2: return {7'h00, 3'd1};
      3: return {7'h00, 3'd2};  4: return {7'h00, 3'd3};  5: return {7'h00, 3'd4};
      6: return {7'h00, 3'd5};  7: return {7'h20, 3'd5};  8: return {7'h00, 3'd6};
      9: return {7'h00, 3'd7};  10: return {7'h01, 3'd0}; 11: return {7'h01, 3'd1};
      12: return {7'h01, 3'd2}; 13: return {7'h01, 3'd3}; 14: return {7'h01, 3'd4};
      15: return {7'h01, 3'd5}; 16: return {7'h01, 3'd6}; default: return {7'h01, 3'd7};
    endcase
  endfunction

  // Immediate mnemonics ADDI..SRAI: {funct3, code, funct7, is_shift}
  function automatic logic [15:0] i_code(int k);
    case (k)
      0: return {3'd0, 5'd0, 7'h00, 1'b0};  1: return {3'd2, 5'd3, 7'h00, 1'b0};
      2: return {3'd3, 5'd4, 7'h00, 1'b0};  3: return {3'd4, 5'd5, 7'h00, 1'b0};
      4: return {3'd6, 5'd8, 7'h00, 1'b0};  5: return {3'd7, 5'd9, 7'h00, 1'b0};
      6: return {3'd1, 5'd2, 7'h00, 1'b1};  7: return {3'd5, 5'd6, 7'h00, 1'b1};
      default: return {3'd5, 5'd7, 7'h20, 1'b1};
    endcase
  endfunction

  task automatic gen_txn(output logic [31:0] ins, output logic [31:0] r1, output logic [31:0] r2,
                         output logic [EW-1:0] e);
    int cat, k;
    logic [9:0] rc;
    logic [15:0] ic;
    logic [6:0] f7, op;
    logic [2:0] f3;
    logic [4:0] ctr;
    logic [11:0] imm;
    logic [31:0] o2;
    logic ill, dv;
    r1 = $urandom; r2 = $urandom; imm = 12'($urandom);
    ill = 1'b0; dv = 1'b0; ctr = '0; o2 = '0;
    cat = $urandom_range(0, 9);
    if (cat < 5) begin
      k = $urandom_range(0, 17);
      rc = r_code(k);
      ins = enc_r(rc[9:3], rc[2:0], 5'($urandom), 5'($urandom), 5'($urandom));
      ctr = 5'(k);
      o2 = (k == 2 || k == 6 || k == 7) ? (r2 % 32) : r2;
      ill = (k >= 10) && !M_EN;
      dv = M_EN && (k >= 14);
    end else if (cat < 8) begin
      k = $urandom_range(0, 8);
      ic = i_code(k);
      if (ic[0]) imm = {ic[7:1], imm[4:0]};
      ins = enc_i(imm, ic[15:13], 5'($urandom), 5'($urandom));
      ctr = ic[12:8];
      o2 = ic[0] ? 32'(imm % 32) : sext12(imm);
    end else begin
      ill = 1'b1;
      case ($urandom_range(0, 3))
        0: begin
          op = 7'($urandom);
          if (op == 7'b0110011 || op == 7'b0010011) op = 7'b0000011;
          ins = {25'($urandom), op};
        end
        1: begin
          f3 = 3'($urandom);
          if (f3 == 3'd0 || f3 == 3'd5) f3 = 3'd6;
          ins = enc_r(7'h20, f3, 5'($urandom), 5'($urandom), 5'($urandom));
        end
        2: begin
          f7 = 7'($urandom);
          if (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01) f7 = 7'h7f;
          ins = enc_r(f7, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        end
        default: begin
          f3 = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
          f7 = 7'($urandom);
          if (f7 == 7'h00 || f7 == 7'h20) f7 = 7'h41;
          ins = enc_i({f7, 5'($urandom)}, f3, 5'($urandom), 5'($urandom));
        end
      endcase
    end
    if (ill) e = {1'b0, 1'b1, 5'd0, 64'd0};
    else e = {dv, 1'b0, ctr, r1, o2};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic ordy);
    in_valid = v; instr = ins; rs1_data = r1; rs2_data = r2; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, enc_r(7'h00, 3'd0, 5'd2, 5'd1, 5'd3), 32'h1234, 32'h5678, 1'b0);
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if ({obs, in_ready} !== {71'd0, 1'b1})
      begin errors++; $display("FAIL reset: got %h/%b required 0/1", obs, in_ready); end
  endtask

  task automatic test_add();
    do_reset();
    drive(1'b1, enc_r(7'h00, 3'd0, 5'd2, 5'd1, 5'd3), 32'd5, 32'd7, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b required 1", in_ready); end
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd0, 32'd5, 32'd7})
      begin errors++; $display("FAIL add: got %h required %h", obs, {1'b1, 1'b0, 5'd0, 32'd5, 32'd7}); end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b required 0", out_valid); end
  endtask

  task automatic test_sra_imm();
    do_reset();
    drive(1'b1, enc_r(7'h20, 3'd5, 5'd2, 5'd1, 5'd3), 32'h8000_0000, 32'h0000_0024, 1'b1);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd7, 32'h8000_0000, 32'd4})
      begin errors++; $display("FAIL reg_sra: got %h required ctr 7 op2 4", obs); end
    drive(1'b1, enc_i(12'hfff, 3'd0, 5'd1, 5'd4), 32'd1, 32'd99, 1'b1);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd0, 32'd1, 32'hffff_ffff})
      begin errors++; $display("FAIL addi_neg: got %h required op2 ffffffff", obs); end
    drive(1'b1, enc_i({7'h20, 5'd31}, 3'd5, 5'd1, 5'd4), 32'hdead_beef, 32'd0, 1'b1);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd7, 32'hdead_beef, 32'h1f})
      begin errors++; $display("FAIL srai31: got %h required ctr 7 op2 1f", obs); end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    tick();
  endtask

`ifdef ALU_ISSUE_M_EN
  task automatic test_div_hold();
    logic [31:0] div_ins;
    div_ins = enc_r(7'h01, 3'd4, 5'd2, 5'd1, 5'd3);
    do_reset();
    drive(1'b1, div_ins, 32'd100, 32'd7, 1'b0);
    tick();
    for (int k = 0; k < MDIV - 1; k++) begin
      drive(1'b1, enc_r(7'h00, 3'd0, 5'd2, 5'd1, 5'd3), 32'd1, 32'd2, 1'b0);
      checks++;
      if ({out_valid, in_ready, alu_ctr, alu_op1} !== {1'b0, 1'b0, 5'd14, 32'd100})
        begin errors++; $display("FAIL div_hold[%0d]: got v%b r%b ctr %0d op1 %0d required v0 r0 ctr 14 op1 100", k, out_valid, in_ready, alu_ctr, alu_op1); end
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if ({obs, in_ready} !== {1'b1, 1'b0, 5'd14, 32'd100, 32'd7, 1'b0})
      begin errors++; $display("FAIL div_valid: got %h/%b required valid ctr 14", obs, in_ready); end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    tick();
    drive(1'b1, div_ins, 32'd9, 32'd3, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if ({obs, in_ready} !== {71'd0, 1'b1})
      begin errors++; $display("FAIL div_reset: got %h/%b required 0/1", obs, in_ready); end
  endtask
`else
  task automatic test_mul_illegal();
    do_reset();
    drive(1'b1, enc_r(7'h01, 3'd0, 5'd2, 5'd1, 5'd3), 32'd6, 32'd7, 1'b0);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b1, 69'd0})
      begin errors++; $display("FAIL mul_illegal: got %h required valid illegal zeros", obs); end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    tick();
  endtask
`endif

  task automatic test_backpressure();
    logic [31:0] a [3];
    logic [31:0] add_ins;
    add_ins = enc_r(7'h00, 3'd0, 5'd2, 5'd1, 5'd3);
    for (int i = 0; i < 3; i++) a[i] = $urandom;
    do_reset();
    drive(1'b1, add_ins, a[0], 32'd1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, add_ins, a[1], 32'd2, 1'b0);
      checks++;
      if ({obs, in_ready} !== {1'b1, 1'b0, 5'd0, a[0], 32'd1, 1'b0})
        begin errors++; $display("FAIL bp_hold[%0d]: got %h/%b required first held, ready 0", k, obs, in_ready); end
      tick();
    end
    drive(1'b1, add_ins, a[1], 32'd2, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
    tick();
    drive(1'b1, add_ins, a[2], 32'd3, 1'b1);
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd0, a[1], 32'd2})
      begin errors++; $display("FAIL bp_second: got %h required op1 %h", obs, a[1]); end
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd0, a[2], 32'd3})
      begin errors++; $display("FAIL bp_third: got %h required op1 %h", obs, a[2]); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b required 0", out_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = enc_r(7'h20, 3'd1, 5'd2, 5'd1, 5'd3);
    bad[1] = {25'h123456, 7'b0000011};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, bad[i], 32'hffff_0001, 32'h0000_ff02, 1'b1);
      tick();
      checks++;
      if (obs !== {1'b1, 1'b1, 69'd0})
        begin errors++; $display("FAIL illegal[%0d]: got %h required valid illegal zeros", i, obs); end
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] imm;
    logic [31:0] r1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      imm = 12'($urandom);
      r1 = $urandom;
      drive(1'b1, enc_i(imm, 3'd0, 5'd1, 5'd2), r1, 32'd0, 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, in_ready); end
      tick();
      checks++;
      if (obs !== {1'b1, 1'b0, 5'd0, r1, sext12(imm)})
        begin errors++; $display("FAIL b2b[%0d]: got %h required %h", i, obs, {1'b1, 1'b0, 5'd0, r1, sext12(imm)}); end
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    logic v, ordy, exp_valid, exp_ready;
    logic [31:0] ins, r1, r2;
    logic [EW-1:0] e, front;
    int wait_cnt;
    do_reset();
    wait_cnt = 0;
    for (int c = 0; c < 500; c++) begin
      v = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      gen_txn(ins, r1, r2, e);
      drive(v, ins, r1, r2, ordy);
      exp_valid = (exp_q.size() != 0) && (wait_cnt == 0);
      exp_ready = (exp_q.size() == 0) || (exp_valid && ordy);
      checks++;
      if ({out_valid, in_ready} !== {exp_valid, exp_ready})
        begin errors++; $display("FAIL rnd_hs[%0d]: got v%b r%b required v%b r%b", c, out_valid, in_ready, exp_valid, exp_ready); end
      if (exp_q.size() != 0) begin
        front = exp_q[0];
        checks++;
        if (obs[69:0] !== front[69:0])
          begin errors++; $display("FAIL rnd_data[%0d]: got %h required %h", c, obs[69:0], front[69:0]); end
      end
      if (exp_valid && ordy) void'(exp_q.pop_front());
      if (v && exp_ready) begin
        exp_q.push_back(e);
        wait_cnt = e[70] ? MDIV - 1 : 0;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sra_imm();
`ifdef ALU_ISSUE_M_EN
    test_div_hold();
`else
    test_mul_illegal();
`endif
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
